// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-channel constants, bridge states and response helpers
// for the instruction/data-side SRAM-to-AXI bridges.
package inst_axi_rd_bridge_pkg;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [3:0] BRIDGE_ID   = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } rd_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/inst_req_slot.sv
// Single-entry address buffer: push loads it, pop empties it, contents visible at once.
// Zero latency; no backpressure -- the owner must only push while empty or popping.
module inst_req_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_push) begin
      r_vld <= 1'b1;
      r_dat <= i_push_dat;
    end else if (i_pop) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// IF-side SRAM port to single-beat AXI3 reads; data_ok 3 cycles after req at best.
// One read in flight plus one queued fetch; addr_ok drops when both are taken. Option: INST_BRIDGE_RESP_ERR_EN.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID      = BRIDGE_ID,
  parameter logic [3:0] ARCACHE_VAL = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_BRIDGE_RESP_ERR_EN
  ,
  output logic        inst_sram_err
`endif
);

  rd_state_t   r_state;
  logic [31:0] r_cur_addr;
  logic [31:0] r_rdata;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_data_ok;

  logic        w_pend_vld;
  logic [31:0] w_pend_addr;
  logic        w_addr_ok;
  logic        w_complete;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;

  // IF does not hold req, so acceptance must be decided in the same cycle.
  assign w_addr_ok  = inst_sram_req && ((r_state == ST_IDLE) || !w_pend_vld);
  assign w_complete = (r_state == ST_R) && rvalid && rlast && (rid == AXI_ID);
  assign w_bypass   = w_complete && w_addr_ok && !w_pend_vld;
  assign w_push     = w_addr_ok && (r_state != ST_IDLE) && !w_bypass;
  assign w_pop      = w_complete && w_pend_vld;

  inst_req_slot #(.W(32)) u_slot (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (inst_sram_addr),
    .i_pop      (w_pop),
    .o_vld      (w_pend_vld),
    .o_dat      (w_pend_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_rdata    <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_data_ok  <= 1'b0;
    end else begin
      r_data_ok <= w_complete;
      if (w_complete) begin
        r_rdata <= rdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_addr_ok) begin
            r_cur_addr <= inst_sram_addr;
            r_arvalid  <= 1'b1;
            r_state    <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (w_complete) begin
            r_rready <= 1'b0;
            // The queued fetch is older than any request arriving now, so it goes first.
            if (w_pend_vld) begin
              r_cur_addr <= w_pend_addr;
              r_arvalid  <= 1'b1;
              r_state    <= ST_AR;
            end else if (w_bypass) begin
              r_cur_addr <= inst_sram_addr;
              r_arvalid  <= 1'b1;
              r_state    <= ST_AR;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INST_BRIDGE_RESP_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_complete) begin
      r_err <= resp_is_err(rresp);
    end
  end

  assign inst_sram_err = r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = resp_is_err(rresp);
`endif

  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = r_data_ok;
  assign inst_sram_rdata   = r_rdata;
  assign arid              = AXI_ID;
  assign araddr            = r_cur_addr;
  assign arlen             = 8'd0;
  assign arsize            = ARSIZE_WORD;
  assign arburst           = BURST_INCR;
  assign arlock            = 2'b00;
  assign arcache           = ARCACHE_VAL;
  assign arprot            = 3'b000;
  assign arvalid           = r_arvalid;
  assign rready            = r_rready;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: AXI slave with tunable delays, queue-based fetch model,
// fixed vector table, corner-case sequences and a randomized traffic phase.
module tb_inst_axi_rd_bridge;

  localparam logic [3:0] TB_ID    = 4'd0;
  localparam logic [3:0] TB_CACHE = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef INST_BRIDGE_RESP_ERR_EN
  logic        inst_sram_err;
`endif

  inst_axi_rd_bridge #(.AXI_ID(TB_ID), .ARCACHE_VAL(TB_CACHE)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
`ifdef INST_BRIDGE_RESP_ERR_EN
    ,
    .inst_sram_err     (inst_sram_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // slave knobs and state
  int          ar_dly = 0;
  int          r_dly  = 0;
  bit          rand_dly = 1'b0;
  int          stray_cnt = 0;
  logic [3:0]  stray_id = 4'd5;
  int          ar_cnt = 0;
  int          r_cnt  = 0;
  bit          real_beat;
  logic [31:0] s_q[$];
  logic [31:0] mem_ovr [logic [31:0]];
  logic [1:0]  resp_ovr [logic [31:0]];

  // reference model
  logic [31:0] aq[$];
  logic [31:0] mq[$];
  int          outstanding = 0;
  bit          dok_exp = 1'b0;
  logic [31:0] dok_dat_exp;
  logic        dok_err_exp;
  logic [31:0] hold_exp = '0;
  bit          prev_ar_wait = 1'b0;
  logic [31:0] prev_araddr;

  // logs
  logic [31:0] dok_log[$];
  logic [31:0] ar_log[$];
  logic        last_err;
  int drop_cnt = 0, ar_hs_cnt = 0, dok_cnt = 0, last_dok_cyc = 0, last_hs_cyc = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], a[31:16]} ^ 32'h3c1d_5a5a;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (resp_ovr.exists(a)) return resp_ovr[a];
    return a[9:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input bit i_req, input logic [31:0] i_addr, input bit i_rst);
    bit exp_ok;
    if (i_rst) begin
      aq.delete(); mq.delete(); s_q.delete();
      outstanding = 0; dok_exp = 1'b0; hold_exp = '0;
      prev_ar_wait = 1'b0; ar_cnt = 0; r_cnt = 0;
    end else begin
      check("data_ok", inst_sram_data_ok, dok_exp);
      if (inst_sram_data_ok && dok_exp) begin
        check("rdata", inst_sram_rdata, dok_dat_exp);
`ifdef INST_BRIDGE_RESP_ERR_EN
        check("err", inst_sram_err, dok_err_exp);
        last_err = inst_sram_err;
`endif
        dok_log.push_back(inst_sram_rdata);
        dok_cnt++;
        last_dok_cyc = cyc;
        hold_exp = dok_dat_exp;
      end else if (!inst_sram_data_ok) begin
        check("rdata_hold", inst_sram_rdata, hold_exp);
      end
      dok_exp = 1'b0;

      if (prev_ar_wait) begin
        check("arvalid_hold", arvalid, 1);
        check("araddr_hold", araddr, prev_araddr);
      end
      prev_ar_wait = arvalid && !arready;
      prev_araddr  = araddr;

      if (outstanding == 0) begin
        check("idle_arvalid", arvalid, 0);
        check("idle_rready", rready, 0);
      end

      if (i_req) begin
        exp_ok = (outstanding < 2);
        check("addr_ok", inst_sram_addr_ok, exp_ok);
        if (!inst_sram_addr_ok) begin
          drop_cnt++;
          $display("protocol: fetch %h dropped, bridge full (cycle %0d)", i_addr, cyc);
        end
        if (exp_ok) begin
          aq.push_back(i_addr);
          mq.push_back(i_addr);
        end
      end else begin
        check("addr_ok_noreq", inst_sram_addr_ok, 0);
      end

      if (arvalid && arready) begin
        ar_hs_cnt++;
        ar_log.push_back(araddr);
        if (aq.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got araddr %h, want no request", araddr);
        end else begin
          check("araddr", araddr, aq.pop_front());
        end
        s_q.push_back(araddr);
        ar_cnt = 0;
        if (rand_dly) ar_dly = $urandom_range(0, 3);
      end

      if (rvalid && rready && real_beat) begin
        void'(s_q.pop_front());
        r_cnt = 0;
        if (rand_dly) r_dly = $urandom_range(0, 3);
        last_hs_cyc = cyc;
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got beat %h, want none", rdata);
        end else begin
          logic [31:0] a;
          a = mq.pop_front();
          outstanding--;
          dok_exp     = 1'b1;
          dok_dat_exp = mem_data(a);
          dok_err_exp = mem_resp(a)[1];
        end
      end

      if (i_req && exp_ok) outstanding++;
    end
  endtask

  task automatic cycle(input bit i_req, input logic [31:0] i_addr, input bit i_rst);
    @(negedge clk);
    cyc++;
    reset = i_rst;
    inst_sram_req  = i_req;
    inst_sram_addr = i_addr;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = TB_ID;
    rdata = '0; rresp = 2'b00; real_beat = 1'b0;
    if (!i_rst) begin
      if (arvalid) begin
        if (ar_cnt >= ar_dly) arready = 1'b1;
        else ar_cnt++;
      end
      if (stray_cnt > 0) begin
        rvalid = 1'b1; rlast = 1'b1; rid = stray_id;
        rdata = 32'hdead_0000 | 32'(stray_cnt);
        stray_cnt--;
      end else if (s_q.size() > 0) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1'b1; rlast = 1'b1; real_beat = 1'b1;
          rdata = mem_data(s_q[0]); rresp = mem_resp(s_q[0]);
        end else begin
          r_cnt++;
        end
      end
    end
    #1;
    observe(i_req, i_addr, i_rst);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((outstanding > 0 || dok_exp) && k < budget) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    check("drain_done", 32'(outstanding == 0 && !dok_exp), 1);
  endtask

  task automatic wait_rready(input int budget);
    int k = 0;
    while (rready !== 1'b1 && k < budget) begin
      cycle(1'b0, 32'h0, 1'b0);
      k++;
    end
    check("wait_rready", rready, 1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ar_d;
    int          r_d;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k0, d0, h0, t0, hi;
    vecs[0] = '{32'h1fc0_0000, 32'h3c1d_0000, 0, 0, 3};
    vecs[1] = '{32'h1fc0_0004, 32'h27bd_fff0, 2, 0, 5};
    vecs[2] = '{32'h8000_1000, 32'h0000_0000, 0, 3, 6};
    vecs[3] = '{32'hffff_fffc, 32'hffff_ffff, 1, 1, 5};
    vecs[4] = '{32'h0000_0000, 32'h1234_5678, 4, 2, 9};

    reset = 1'b1; inst_sram_req = 1'b0; inst_sram_addr = '0;
    arready = 1'b0; rid = TB_ID; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_data_ok", inst_sram_data_ok, 0);
    check("rst_rdata", inst_sram_rdata, 0);
    check("rst_araddr", araddr, 0);
    check("const_ar", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
          {TB_ID, 8'd0, 3'b010, 2'b01, 2'b00, TB_CACHE, 3'b000});
`ifdef INST_BRIDGE_RESP_ERR_EN
    check("rst_err", inst_sram_err, 0);
`endif

    for (int i = 0; i < 5; i++) begin
      mem_ovr[vecs[i].addr] = vecs[i].data;
      ar_dly = vecs[i].ar_d;
      r_dly  = vecs[i].r_d;
      t0 = cyc + 1;
      cycle(1'b1, vecs[i].addr, 1'b0);
      drain(60);
      check("tbl_latency", 32'(last_dok_cyc - t0), 32'(vecs[i].lat));
      check("tbl_rdata", dok_log[$], vecs[i].data);
      check("tbl_araddr", ar_log[$], vecs[i].addr);
      idle(1);
    end

    // AR stall: arvalid and araddr must sit still for 6 cycles, one handshake
    ar_dly = 5; r_dly = 0; h0 = ar_hs_cnt; hi = 0;
    cycle(1'b1, 32'h40, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (arvalid && araddr == 32'h40) hi++;
    end
    drain(40);
    check("stall_arvalid_cycles", 32'(hi), 6);
    check("stall_one_handshake", 32'(ar_hs_cnt - h0), 1);

    // flush re-request while the first fetch waits in R
    ar_dly = 0; r_dly = 3;
    mem_ovr[32'h100] = 32'h0000_aaaa;
    mem_ovr[32'h200] = 32'h0000_bbbb;
    n0 = dok_log.size();
    cycle(1'b1, 32'h100, 1'b0);
    wait_rready(10);
    cycle(1'b1, 32'h200, 1'b0);
    check("flush_addr_ok", inst_sram_addr_ok, 1);
    drain(40);
    check("flush_count", 32'(dok_log.size() - n0), 2);
    check("flush_first", dok_log[n0], 32'h0000_aaaa);
    check("flush_second", dok_log[n0+1], 32'h0000_bbbb);
    check("flush_araddr", ar_log[$], 32'h200);

    // request in the completion cycle bypasses the slot
    ar_dly = 0; r_dly = 2;
    cycle(1'b1, 32'h100, 1'b0);
    idle(3);
    cycle(1'b1, 32'h300, 1'b0);
    check("bypass_same_cycle", 32'(last_hs_cyc), 32'(cyc));
    check("bypass_addr_ok", inst_sram_addr_ok, 1);
    cycle(1'b0, 32'h0, 1'b0);
    check("bypass_arvalid", arvalid, 1);
    check("bypass_araddr", araddr, 32'h300);
    check("bypass_data_ok", inst_sram_data_ok, 1);
    cycle(1'b1, 32'h304, 1'b0);
    check("bypass_slot_empty", inst_sram_addr_ok, 1);
    drain(40);

    // third request while one is in flight and one queued
    ar_dly = 0; r_dly = 4; d0 = drop_cnt; k0 = dok_cnt;
    cycle(1'b1, 32'h500, 1'b0);
    idle(1);
    cycle(1'b1, 32'h504, 1'b0);
    cycle(1'b1, 32'h508, 1'b0);
    check("full_addr_ok", inst_sram_addr_ok, 0);
    check("full_drop_seen", 32'(drop_cnt - d0), 1);
    drain(40);
    check("full_returns", 32'(dok_cnt - k0), 2);

    // responses with a foreign rid are consumed but ignored
    ar_dly = 0; r_dly = 4; k0 = dok_cnt;
    cycle(1'b1, 32'h600, 1'b0);
    wait_rready(10);
    stray_id = TB_ID ^ 4'h5; stray_cnt = 2;
    idle(2);
    check("stray_no_data_ok", 32'(dok_cnt - k0), 0);
    drain(40);
    check("stray_one_return", 32'(dok_cnt - k0), 1);
    check("stray_rdata", dok_log[$], mem_data(32'h600));

    // reset while waiting on R
    ar_dly = 0; r_dly = 20; k0 = dok_cnt;
    cycle(1'b1, 32'h700, 1'b0);
    wait_rready(10);
    idle(1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_data_ok", inst_sram_data_ok, 0);
    stray_id = TB_ID; stray_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      check("midrst_no_ack", rready, 0);
    end
    idle(2);
    check("midrst_no_return", 32'(dok_cnt - k0), 0);
    r_dly = 0;
    cycle(1'b1, 32'h704, 1'b0);
    drain(40);
    check("midrst_recover", dok_log[$], mem_data(32'h704));

`ifdef INST_BRIDGE_RESP_ERR_EN
    resp_ovr[32'h800] = 2'b10;
    resp_ovr[32'h804] = 2'b00;
    cycle(1'b1, 32'h800, 1'b0);
    drain(40);
    check("err_slverr", last_err, 1);
    cycle(1'b1, 32'h804, 1'b0);
    drain(40);
    check("err_okay", last_err, 0);
`endif

    // randomized traffic against the model
    rand_dly = 1'b1;
    for (int k = 0; k < 800; k++) begin
      bit r;
      r = ($urandom_range(0, 3) == 0);
      if (r && outstanding >= 2 && $urandom_range(0, 7) != 0) r = 1'b0;
      if (stray_cnt == 0 && $urandom_range(0, 29) == 0) begin
        stray_id = TB_ID ^ 4'($urandom_range(1, 15));
        stray_cnt = 1;
      end
      cycle(r, $urandom() & 32'hffff_fffc, 1'b0);
    end
    rand_dly = 1'b0; ar_dly = 0; r_dly = 0;
    drain(100);
    check("model_empty", 32'(aq.size() + mq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
